sdram_controller: RTL and testbench

//  Initiator side of the SDRAM block interface: turns single-beat CPU memory requests into

---
 rtl/sdram_controller.sv | 120 ++++++++++++
 tb/tb_sdram_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_controller.sv
// rtl/sdram_controller.sv - single-beat CPU request to sdram_block bus cycle controller
// Tracks the open bank and charges the bank-switch hold only when the bank changes.
module sdram_controller #(
   parameter int BANK_SWITCH_DELAY = 140,
   parameter int READ_LATENCY      = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [14:0] req_address,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        sdram_wr_en,
   output logic [12:0] sdram_column_address,
   output logic [1:0]  sdram_bank_address,
   inout  wire  [31:0] sdram_rw_data
);

   localparam int MAX_LOAD = (BANK_SWITCH_DELAY > READ_LATENCY) ? BANK_SWITCH_DELAY : READ_LATENCY;
   localparam int CNT_W    = $clog2(MAX_LOAD + 1);
   localparam logic [CNT_W-1:0] BANK_LOAD = CNT_W'(BANK_SWITCH_DELAY - 1);
   localparam logic [CNT_W-1:0] READ_LOAD = CNT_W'(READ_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BANK_SWITCH, WRITE, READ_WAIT} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] counter, counter_next;
   logic             resp_next;
   logic             sample;
   logic             accept;
   logic             bank_open;
   logic             write_q;
   logic [31:0]      wdata_q;

   assign req_ready     = (state == IDLE) && !reset;
   assign accept        = req_valid && req_ready;
   assign sdram_wr_en   = (state == WRITE);
   assign sdram_rw_data = (state == WRITE) ? wdata_q : 32'bz;

   always_comb begin
      state_next   = state;
      counter_next = counter;
      resp_next    = 1'b0;
      sample       = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!bank_open || (req_address[14:13] != sdram_bank_address)) begin
                  state_next   = BANK_SWITCH;
                  counter_next = BANK_LOAD;
               end else if (req_write) begin
                  state_next = WRITE;
               end else begin
                  state_next   = READ_WAIT;
                  counter_next = READ_LOAD;
               end
            end
         end
         BANK_SWITCH: begin
            if (counter == '0) begin
               if (write_q) begin
                  state_next = WRITE;
               end else begin
                  state_next   = READ_WAIT;
                  counter_next = READ_LOAD;
               end
            end else begin
               counter_next = counter - 1'b1;
            end
         end
         WRITE: begin
            state_next = IDLE;
            resp_next  = 1'b1;
         end
         READ_WAIT: begin
            if (counter == '0) begin
               state_next = IDLE;
               resp_next  = 1'b1;
               sample     = 1'b1;
            end else begin
               counter_next = counter - 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // sdram_bank_address doubles as the open-bank register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state                <= IDLE;
         counter              <= '0;
         resp_valid           <= 1'b0;
         resp_rdata           <= '0;
         sdram_column_address <= '0;
         sdram_bank_address   <= '0;
         bank_open            <= 1'b0;
         write_q              <= 1'b0;
         wdata_q              <= '0;
      end else begin
         state      <= state_next;
         counter    <= counter_next;
         resp_valid <= resp_next;
         if (accept) begin
            write_q              <= req_write;
            wdata_q              <= req_wdata;
            sdram_column_address <= req_address[12:0];
            sdram_bank_address   <= req_address[14:13];
            bank_open            <= 1'b1;
         end
         if (sample) begin
            resp_rdata <= sdram_rw_data;
         end
      end
   end

endmodule

// File: tb/tb_sdram_controller.sv
// tb/tb_sdram_controller.sv - directed bench for sdram_controller with a simple SDRAM memory model
// The model drives the bus whenever wr_en is low, so any stray controller drive corrupts the read value.
module tb_sdram_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [14:0] req_address;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        sdram_wr_en;
   logic [12:0] sdram_column_address;
   logic [1:0]  sdram_bank_address;
   wire  [31:0] sdram_rw_data;

   logic [31:0] mem [0:32767];

   int          checks = 0;
   int          errors = 0;
   int          lat, wr_cnt, pulses, first_k, second_k, quiet_resp, quiet_wr;
   logic [31:0] rd, wr_val, first_d, second_d;
   logic        rdy_low, bank_ok, bus_check_en;

   sdram_controller #(.BANK_SWITCH_DELAY(140), .READ_LATENCY(2)) dut (
      .clock                (clock),
      .reset                (reset),
      .req_valid            (req_valid),
      .req_ready            (req_ready),
      .req_write            (req_write),
      .req_address          (req_address),
      .req_wdata            (req_wdata),
      .resp_valid           (resp_valid),
      .resp_rdata           (resp_rdata),
      .sdram_wr_en          (sdram_wr_en),
      .sdram_column_address (sdram_column_address),
      .sdram_bank_address   (sdram_bank_address),
      .sdram_rw_data        (sdram_rw_data)
   );

   always #5 clock = ~clock;

   assign sdram_rw_data = sdram_wr_en ? 32'bz : mem[{sdram_bank_address, sdram_column_address}];

   always @(posedge clock) begin
      if (sdram_wr_en) mem[{sdram_bank_address, sdram_column_address}] <= sdram_rw_data;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Outside WRITE the bus must carry only the model's value
   always @(negedge clock) begin
      if (bus_check_en && !sdram_wr_en)
         check("bus_not_driven", sdram_rw_data, mem[{sdram_bank_address, sdram_column_address}]);
   end

   task automatic txn(input logic wr, input logic [14:0] addr, input logic [31:0] wd,
                      output int lat_o, output logic [31:0] rd_o, output logic rdy_low_o,
                      output int wr_cnt_o, output logic [31:0] wr_val_o, output logic bank_ok_o);
      @(negedge clock);
      check("ready_before_req", {31'd0, req_ready}, 32'd1);
      check("resp_idle_before_req", {31'd0, resp_valid}, 32'd0);
      req_valid   = 1'b1;
      req_write   = wr;
      req_address = addr;
      req_wdata   = wd;
      @(posedge clock);
      #1;
      req_valid   = 1'b0;
      req_write   = ~wr;
      req_address = 15'h7FFF;
      req_wdata   = 32'h0BAD0BAD;
      lat_o = -1; rd_o = '0; rdy_low_o = 1'b1; wr_cnt_o = 0; wr_val_o = '0; bank_ok_o = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clock);
         if (sdram_bank_address != addr[14:13] || sdram_column_address != addr[12:0]) bank_ok_o = 1'b0;
         if (sdram_wr_en) begin
            wr_cnt_o++;
            wr_val_o = sdram_rw_data;
         end
         if (resp_valid) begin
            lat_o = k;
            rd_o  = resp_rdata;
            check("ready_at_resp", {31'd0, req_ready}, 32'd1);
            break;
         end
         if (req_ready) rdy_low_o = 1'b0;
      end
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = 32'hA5000000 ^ i;
      bus_check_en = 1'b1;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_wdata = '0;
      @(negedge clock);
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_wr_en", {31'd0, sdram_wr_en}, 32'd0);
      check("rst_bank", {30'd0, sdram_bank_address}, 32'd0);
      check("rst_column", {19'd0, sdram_column_address}, 32'd0);
      @(posedge clock); #1 reset = 1'b0;

      // first read pays the bank switch
      txn(1'b0, 15'h2005, 32'h0, lat, rd, rdy_low, wr_cnt, wr_val, bank_ok);
      check("rd1_latency", lat, 32'd143);
      check("rd1_data", rd, 32'hA5002005);
      check("rd1_ready_low", {31'd0, rdy_low}, 32'd1);
      check("rd1_no_wr_en", wr_cnt, 32'd0);
      check("rd1_bank_held", {31'd0, bank_ok}, 32'd1);

      txn(1'b1, 15'h2010, 32'hDEADBEEF, lat, rd, rdy_low, wr_cnt, wr_val, bank_ok);
      check("wr_same_latency", lat, 32'd2);
      check("wr_same_wr_cycles", wr_cnt, 32'd1);
      check("wr_same_bus", wr_val, 32'hDEADBEEF);
      check("rdata_kept_after_write", resp_rdata, 32'hA5002005);

      txn(1'b0, 15'h2010, 32'h0, lat, rd, rdy_low, wr_cnt, wr_val, bank_ok);
      check("rd_back_latency", lat, 32'd3);
      check("rd_back_data", rd, 32'hDEADBEEF);

      // alternating banks
      txn(1'b1, 15'h0001, 32'h11111111, lat, rd, rdy_low, wr_cnt, wr_val, bank_ok);
      check("wr_b0_latency", lat, 32'd142);
      check("wr_b0_ready_low", {31'd0, rdy_low}, 32'd1);
      check("wr_b0_bus", wr_val, 32'h11111111);
      txn(1'b1, 15'h4002, 32'h22222222, lat, rd, rdy_low, wr_cnt, wr_val, bank_ok);
      check("wr_b2_latency", lat, 32'd142);
      check("wr_b2_ready_low", {31'd0, rdy_low}, 32'd1);
      check("wr_b2_bank_held", {31'd0, bank_ok}, 32'd1);
      txn(1'b1, 15'h0003, 32'h33333333, lat, rd, rdy_low, wr_cnt, wr_val, bank_ok);
      check("wr_b0_again_latency", lat, 32'd142);
      check("wr_b0_again_wr_cycles", wr_cnt, 32'd1);

      // back-to-back reads with req_valid held high
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b0; req_address = 15'h0001;
      @(posedge clock);
      #1 req_address = 15'h0003;
      pulses = 0; first_k = 0; second_k = 0; first_d = '0; second_d = '0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clock);
         if (resp_valid) begin
            pulses++;
            if (pulses == 1) begin
               first_k = k;
               first_d = resp_rdata;
               check("b2b_ready_at_resp", {31'd0, req_ready}, 32'd1);
            end else begin
               second_k = k;
               second_d = resp_rdata;
            end
         end
         if (k == first_k) begin
            @(posedge clock);
            #1 req_valid = 1'b0;
         end
      end
      check("b2b_pulses", pulses, 32'd2);
      check("b2b_first_cycle", first_k, 32'd3);
      check("b2b_first_data", first_d, 32'h11111111);
      check("b2b_second_cycle", second_k, 32'd6);
      check("b2b_second_data", second_d, 32'h33333333);

      // reset during BANK_SWITCH
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b1; req_address = 15'h6000; req_wdata = 32'h66666666;
      @(posedge clock);
      #1 req_valid = 1'b0;
      repeat (5) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("rst_bs_wr_en", {31'd0, sdram_wr_en}, 32'd0);
      check("rst_bs_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_bs_bus", sdram_rw_data, mem[{sdram_bank_address, sdram_column_address}]);
      check("rst_bs_bank", {30'd0, sdram_bank_address}, 32'd0);
      @(posedge clock); #1 reset = 1'b0;
      quiet_resp = 0; quiet_wr = 0;
      for (int k = 0; k < 160; k++) begin
         @(negedge clock);
         if (resp_valid) quiet_resp++;
         if (sdram_wr_en) quiet_wr++;
      end
      check("rst_bs_no_resp", quiet_resp, 32'd0);
      check("rst_bs_no_write", quiet_wr, 32'd0);
      check("rst_bs_mem_untouched", mem[15'h6000], 32'hA5006000);

      // bank_open cleared: bank 0 repays the delay
      txn(1'b1, 15'h0005, 32'h55555555, lat, rd, rdy_low, wr_cnt, wr_val, bank_ok);
      check("repay_latency", lat, 32'd142);
      check("repay_bus", wr_val, 32'h55555555);

      // reset during WRITE
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b1; req_address = 15'h0006; req_wdata = 32'h77777777;
      @(posedge clock);
      #1 req_valid = 1'b0;
      check("wr_state_wr_en", {31'd0, sdram_wr_en}, 32'd1);
      check("wr_state_bus", sdram_rw_data, 32'h77777777);
      #3 reset = 1'b1;
      #1;
      check("rst_wr_wr_en", {31'd0, sdram_wr_en}, 32'd0);
      check("rst_wr_bus", sdram_rw_data, mem[{sdram_bank_address, sdram_column_address}]);
      @(posedge clock); #1 reset = 1'b0;
      quiet_resp = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         if (resp_valid) quiet_resp++;
      end
      check("rst_wr_no_resp", quiet_resp, 32'd0);
      check("rst_wr_mem_untouched", mem[15'h0006], 32'hA5000006);

      txn(1'b0, 15'h0005, 32'h0, lat, rd, rdy_low, wr_cnt, wr_val, bank_ok);
      check("after_rst_rd_latency", lat, 32'd143);
      check("after_rst_rd_data", rd, 32'h55555555);

      bus_check_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
